// File: rtl/wb_sdram_arbiter.sv
// Two-master Wishbone B3 arbiter in front of the SDRAM controller port.
// m0 = CPU instruction bus, m1 = CPU data bus. Round-robin grant that is
// held for the whole cyc. A watchdog aborts slave cycles that stall too
// long and reports the abort to the owner as err.
module wb_sdram_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 11
) (
  input  logic            wb_clk,
  input  logic            wb_rst_n,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic [2:0]      m0_cti_i,
  input  logic [1:0]      m0_bte_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic [2:0]      m1_cti_i,
  input  logic [1:0]      m1_bte_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic [2:0]      s_cti_o,
  output logic [1:0]      s_bte_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  output logic [1:0]      grant_o,
  output logic            timeout_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  logic [1:0]      state_reg, state_next;
  logic            last_reg, last_next;
  logic [TO_W-1:0] wd_cnt_reg, wd_cnt_next;
  logic            abort_reg, abort_next;
  logic            abort_own_reg, abort_own_next;

  // Masters gathered into arrays so the response path is one generate loop
  logic [AW-1:0]   m_adr [2];
  logic [DW-1:0]   m_dat [2];
  logic [DW/8-1:0] m_sel [2];
  logic [2:0]      m_cti [2];
  logic [1:0]      m_bte [2];
  logic [1:0]      m_we, m_cyc, m_stb, m_ack, m_err, req, own;
  logic            owner, stalled, trip;

  assign m_adr[0] = m0_adr_i;  assign m_adr[1] = m1_adr_i;
  assign m_dat[0] = m0_dat_i;  assign m_dat[1] = m1_dat_i;
  assign m_sel[0] = m0_sel_i;  assign m_sel[1] = m1_sel_i;
  assign m_cti[0] = m0_cti_i;  assign m_cti[1] = m1_cti_i;
  assign m_bte[0] = m0_bte_i;  assign m_bte[1] = m1_bte_i;
  assign m_we     = {m1_we_i, m0_we_i};
  assign m_cyc    = {m1_cyc_i, m0_cyc_i};
  assign m_stb    = {m1_stb_i, m0_stb_i};
  assign req      = m_cyc & m_stb;

  // One-hot ownership straight from the state register; the illegal
  // encoding owns nothing and falls back to IDLE
  assign own     = {state_reg == OWN1, state_reg == OWN0};
  assign owner   = (state_reg == OWN1);
  assign grant_o = own;

  // Abort is reported in the cycle after the trip, when the state is
  // already IDLE, so the slave is disconnected and any late ack is dropped
  assign timeout_o = abort_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_resp
      assign m_ack[gi] = own[gi] & s_ack_i;
      assign m_err[gi] = (own[gi] & s_err_i) | (abort_reg & (abort_own_reg == 1'(gi)));
    end
  endgenerate

  assign m0_ack_o = m_ack[0];
  assign m1_ack_o = m_ack[1];
  assign m0_err_o = m_err[0];
  assign m1_err_o = m_err[1];
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  // Route the owner's request to the slave; everything reads 0 when idle
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_cti_o = '0;
    s_bte_o = '0;
    if (|own) begin
      s_adr_o = m_adr[owner];
      s_dat_o = m_dat[owner];
      s_sel_o = m_sel[owner];
      s_we_o  = m_we[owner];
      s_cyc_o = m_cyc[owner];
      s_stb_o = m_stb[owner];
      s_cti_o = m_cti[owner];
      s_bte_o = m_bte[owner];
    end
  end

  assign stalled = (TIMEOUT_CYCLES != 0) && (|own) && s_cyc_o && s_stb_o && !s_ack_i && !s_err_i;
  assign trip    = stalled && (wd_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));

  // Arbitration, burst lock and watchdog next-state logic
  always_comb begin
    state_next     = state_reg;
    last_next      = last_reg;
    abort_next     = 1'b0;
    abort_own_next = abort_own_reg;
    case (state_reg)
      IDLE: begin
        if (req[0] && (!req[1] || last_reg)) begin
          state_next = OWN0;
          last_next  = 1'b0;
        end else if (req[1]) begin
          state_next = OWN1;
          last_next  = 1'b1;
        end
      end
      OWN0, OWN1: begin
        if (!m_cyc[owner]) begin
          state_next = IDLE;
        end else if (trip) begin
          state_next     = IDLE;
          abort_next     = 1'b1;
          abort_own_next = owner;
        end
      end
      default: state_next = IDLE;
    endcase
    if (!stalled || (state_next == IDLE)) begin
      wd_cnt_next = '0;
    end else begin
      wd_cnt_next = wd_cnt_reg + 1'b1;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      state_reg     <= IDLE;
      last_reg      <= 1'b1;
      wd_cnt_reg    <= '0;
      abort_reg     <= 1'b0;
      abort_own_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      last_reg      <= last_next;
      wd_cnt_reg    <= wd_cnt_next;
      abort_reg     <= abort_next;
      abort_own_reg <= abort_own_next;
    end
  end

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// Directed bench for wb_sdram_arbiter: slave responses are driven by the
// sequence, each one pushes the expected ack (master, data) into a queue,
// and a monitor pops and compares whenever either master sees an ack.
module tb_wb_sdram_arbiter;

  logic        wb_clk, wb_rst_n;
  logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        m0_we_i, m0_cyc_i, m0_stb_i, m1_we_i, m1_cyc_i, m1_stb_i;
  logic [2:0]  m0_cti_i, m1_cti_i;
  logic [1:0]  m0_bte_i, m1_bte_i;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_cyc_o, s_stb_o;
  logic [2:0]  s_cti_o;
  logic [1:0]  s_bte_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i, s_err_i;
  logic [1:0]  grant_o;
  logic        timeout_o;

  int errors = 0;
  int checks = 0;
  bit mon_en = 0;

  typedef struct packed {
    logic        mst;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  wb_sdram_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYCLES(16), .TO_W(5)) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_cti_i(m0_cti_i), .m0_bte_i(m0_bte_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_cti_i(m1_cti_i), .m1_bte_i(m1_bte_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  task automatic nxt();
    @(negedge wb_clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input int m, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat, input logic [2:0] cti);
    if (m == 0) begin
      m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we; m0_adr_i = adr;
      m0_dat_i = dat; m0_cti_i = cti; m0_sel_i = 4'hF; m0_bte_i = 2'b00;
    end else begin
      m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we; m1_adr_i = adr;
      m1_dat_i = dat; m1_cti_i = cti; m1_sel_i = 4'hF; m1_bte_i = 2'b00;
    end
  endtask

  task automatic ack_to(input logic mst, input logic [31:0] d);
    s_ack_i = 1'b1;
    s_dat_i = d;
    exp_q.push_back({mst, d});
  endtask

  task automatic no_ack();
    s_ack_i = 1'b0;
    s_dat_i = 32'h0;
  endtask

  // Ack monitor: every ack seen by a master must match the queue head
  initial begin
    exp_t e;
    forever begin
      @(negedge wb_clk);
      #2;
      if (mon_en && (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", {62'd0, m1_ack_o, m0_ack_o}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          $display("ack m%0d data=%08h", e.mst, m0_dat_o);
          chk("ack_route", {62'd0, m1_ack_o, m0_ack_o}, e.mst ? 64'd2 : 64'd1);
          chk("ack_data_m0", {32'd0, m0_dat_o}, {32'd0, e.data});
          chk("ack_data_m1", {32'd0, m1_dat_o}, {32'd0, e.data});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int stall_cnt;
    bit found;
    wb_rst_n = 1'b0;
    set_m(0, 0, 0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0, 0, 0);
    no_ack();
    s_err_i = 1'b0;

    // Reset state
    nxt(); #1;
    chk("rst_grant", grant_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_s_cyc", s_cyc_o, 0);
    chk("rst_s_stb", s_stb_o, 0);
    chk("rst_s_we", s_we_o, 0);
    chk("rst_acks", {m1_ack_o, m0_ack_o, m1_err_o, m0_err_o}, 0);
    wb_rst_n = 1'b1;
    mon_en = 1'b1;

    // Single m1 read, slave acks two cycles after stb
    nxt();
    set_m(1, 1, 1, 0, 32'h100, 0, 3'b000); #1;
    chk("t1_no_grant_yet", grant_o, 0);
    chk("t1_s_cyc_before", s_cyc_o, 0);
    nxt(); #1;
    chk("t1_grant", grant_o, 2'b10);
    chk("t1_s_cyc", s_cyc_o, 1);
    chk("t1_s_adr", s_adr_o, 32'h100);
    nxt(); #1;
    chk("t1_wait_ack", m1_ack_o, 0);
    nxt();
    ack_to(1, 32'hDEADBEEF); #1;
    chk("t1_m0_ack", m0_ack_o, 0);
    chk("t1_m1_ack", m1_ack_o, 1);
    nxt();
    no_ack(); set_m(1, 0, 0, 0, 0, 0, 0); #1;
    chk("t1_grant_held", grant_o, 2'b10);
    nxt(); #1;
    chk("t1_grant_idle", grant_o, 0);
    chk("t1_s_adr_idle", s_adr_o, 0);

    // Tie: pointer says m1 was last, so m0 first, then m1 after a gap
    set_m(0, 1, 1, 0, 32'hA0, 0, 0);
    set_m(1, 1, 1, 0, 32'hB0, 0, 0);
    nxt();
    ack_to(0, 32'h11111111); #1;
    chk("tie1_grant_m0", grant_o, 2'b01);
    chk("tie1_s_adr", s_adr_o, 32'hA0);
    chk("tie1_m1_waits", m1_ack_o, 0);
    nxt();
    no_ack(); set_m(0, 0, 0, 0, 0, 0, 0); #1;
    chk("tie1_s_cyc_drop", s_cyc_o, 0);
    nxt(); #1;
    chk("tie1_gap_grant", grant_o, 0);
    chk("tie1_gap_s_cyc", s_cyc_o, 0);
    nxt();
    ack_to(1, 32'h22222222); #1;
    chk("tie1_grant_m1", grant_o, 2'b10);
    chk("tie1_s_adr_m1", s_adr_o, 32'hB0);
    nxt();
    no_ack(); set_m(1, 0, 0, 0, 0, 0, 0);
    nxt(); #1;
    chk("tie1_idle", grant_o, 0);

    // m0 8-beat incrementing burst with a strobe gap while m1 waits
    set_m(0, 1, 1, 0, 32'h1000, 0, 3'b010);
    nxt(); #1;
    chk("burst_grant", grant_o, 2'b01);
    set_m(1, 1, 1, 1, 32'hB00, 32'hBBBB, 0);
    for (int b = 0; b < 8; b++) begin
      if (b == 4) begin
        set_m(0, 1, 0, 0, 32'h1000 + 32'(4 * b), 0, 3'b010);
        no_ack(); #1;
        chk("burst_gap_grant", grant_o, 2'b01);
        chk("burst_gap_stb", s_stb_o, 0);
        nxt();
      end
      set_m(0, 1, 1, 0, 32'h1000 + 32'(4 * b), 0, (b == 7) ? 3'b111 : 3'b010);
      ack_to(0, 32'hC0DE0000 + 32'(b)); #1;
      chk("burst_lock", grant_o, 2'b01);
      chk("burst_s_adr", s_adr_o, 32'h1000 + 32'(4 * b));
      chk("burst_m1_no_ack", m1_ack_o, 0);
      nxt();
    end
    no_ack(); set_m(0, 0, 0, 0, 0, 0, 0); #1;
    chk("burst_end_grant", grant_o, 2'b01);
    nxt(); #1;
    chk("burst_gap_grant0", grant_o, 0);
    chk("burst_gap_s_cyc", s_cyc_o, 0);
    nxt();
    ack_to(1, 32'h12345678); #1;
    chk("burst_m1_granted", grant_o, 2'b10);
    chk("burst_m1_we", s_we_o, 1);
    chk("burst_m1_dat", s_dat_o, 32'hBBBB);
    nxt();
    no_ack(); set_m(1, 0, 0, 0, 0, 0, 0);
    nxt(); #1;
    chk("burst_idle", grant_o, 0);

    // Watchdog: m1 write that the slave never acks
    set_m(1, 1, 1, 1, 32'h2000, 32'h5555, 0);
    nxt();
    stall_cnt = 0;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (m1_err_o === 1'b1) begin
        found = 1;
        break;
      end
      if (s_cyc_o === 1'b1) stall_cnt++;
      nxt();
    end
    chk("wd_fired", found, 1);
    chk("wd_stall_cycles", stall_cnt, 16);
    chk("wd_timeout", timeout_o, 1);
    chk("wd_s_cyc", s_cyc_o, 0);
    chk("wd_grant", grant_o, 0);
    chk("wd_m0_err", m0_err_o, 0);
    set_m(1, 0, 0, 0, 0, 0, 0);
    nxt(); #1;
    chk("wd_timeout_pulse", timeout_o, 0);
    chk("wd_err_pulse", m1_err_o, 0);
    set_m(0, 1, 1, 0, 32'h3000, 0, 0);
    nxt();
    ack_to(0, 32'h33333333); #1;
    chk("wd_after_grant", grant_o, 2'b01);
    chk("wd_after_m0_err", m0_err_o, 0);
    nxt();
    no_ack(); set_m(0, 0, 0, 0, 0, 0, 0);
    nxt(); #1;
    chk("wd_after_idle", grant_o, 0);

    // Tie again: m0 was served last, so m1 wins this time
    set_m(0, 1, 1, 0, 32'h40, 0, 0);
    set_m(1, 1, 1, 0, 32'h50, 0, 0);
    nxt();
    ack_to(1, 32'h44444444); #1;
    chk("tie2_grant_m1", grant_o, 2'b10);
    chk("tie2_s_adr", s_adr_o, 32'h50);
    nxt();
    no_ack(); set_m(1, 0, 0, 0, 0, 0, 0);
    nxt(); #1;
    chk("tie2_gap", grant_o, 0);
    set_m(1, 1, 1, 0, 32'h50, 0, 0);

    // m0 ack coincides with its cyc drop while m1 is pending
    nxt();
    ack_to(0, 32'h66666666); set_m(0, 0, 0, 0, 0, 0, 0); #1;
    chk("ackdrop_grant", grant_o, 2'b01);
    chk("ackdrop_m0_ack", m0_ack_o, 1);
    nxt(); #1;
    chk("ackdrop_idle_grant", grant_o, 0);
    chk("ackdrop_no_dup", {m1_ack_o, m0_ack_o}, 0);
    nxt();
    ack_to(1, 32'h77777777); #1;
    chk("ackdrop_next_owner", grant_o, 2'b10);
    nxt();
    no_ack(); set_m(1, 0, 0, 0, 0, 0, 0);
    nxt(); #1;
    chk("ackdrop_idle", grant_o, 0);

    // Reset pulse in the middle of an m0 burst
    set_m(0, 1, 1, 0, 32'h4000, 0, 3'b010);
    nxt();
    ack_to(0, 32'hA0A00000); #1;
    chk("rstb_grant", grant_o, 2'b01);
    nxt();
    set_m(0, 1, 1, 0, 32'h4004, 0, 3'b010);
    ack_to(0, 32'hA0A00001);
    nxt();
    no_ack();
    set_m(0, 1, 1, 0, 32'h4008, 0, 3'b010);
    set_m(1, 1, 1, 0, 32'h60, 0, 0);
    wb_rst_n = 1'b0;
    nxt();
    wb_rst_n = 1'b1;
    s_ack_i = 1'b1; s_dat_i = 32'hBAD0BAD0; #1;
    chk("rstb_s_cyc", s_cyc_o, 0);
    chk("rstb_grant0", grant_o, 0);
    chk("rstb_no_ack", m0_ack_o, 0);
    nxt();
    set_m(0, 1, 1, 0, 32'h4008, 0, 3'b111);
    ack_to(0, 32'hA0A00002); #1;
    chk("rstb_tie_m0", grant_o, 2'b01);
    nxt();
    no_ack(); set_m(0, 0, 0, 0, 0, 0, 0);
    nxt(); #1;
    chk("rstb_gap", grant_o, 0);
    nxt();
    ack_to(1, 32'h88888888); #1;
    chk("rstb_m1_grant", grant_o, 2'b10);
    nxt();
    no_ack(); set_m(1, 0, 0, 0, 0, 0, 0);
    nxt(); #3;
    chk("final_idle", grant_o, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_sdram_arbiter.md
Name: wb_sdram_arbiter

Overview:
Two-master Wishbone B3 arbiter that shares the single SDRAM controller Wishbone port between the CPU instruction bus (m0) and the data bus (m1).
- Round-robin grant; the grant is held for the whole cyc (including CTI/BTE bursts).
- A bus-watchdog aborts stalled slave cycles with err.
- Sits in picorv32_wb_soc between the CPU bus adapters and the SDRAM controller's wb side, in the wb_clk domain.

Parameters:
AW, 32, address width
DW, 32, data width (sel width = DW/8)
TIMEOUT_CYCLES, 1024, cycles with stb high and no ack/err before abort; 0 disables the watchdog
TO_W, 11, watchdog counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES

Ports:
wb_clk  in  1  clock
wb_rst_n  in  1  synchronous active-low reset
m0_adr_i / m1_adr_i  in  AW  master address
m0_dat_i / m1_dat_i  in  DW  master write data
m0_sel_i / m1_sel_i  in  DW/8  byte selects
m0_we_i / m1_we_i  in  1  write enable
m0_cyc_i / m1_cyc_i  in  1  cycle
m0_stb_i / m1_stb_i  in  1  strobe
m0_cti_i / m1_cti_i  in  3  cycle type
m0_bte_i / m1_bte_i  in  2  burst type
m0_dat_o / m1_dat_o  out  DW  read data (s_dat_i broadcast to both)
m0_ack_o / m1_ack_o  out  1  ack
m0_err_o / m1_err_o  out  1  error
s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o  out  AW/DW/DW/8/1/1/1/3/2  slave request
s_dat_i  in  DW  slave read data
s_ack_i  in  1  slave ack
s_err_i  in  1  slave error
grant_o  out  2  one-hot current owner (bit0 = m0)
timeout_o  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (wb_rst_n low at a posedge): state IDLE, round-robin pointer last=1 (m0 wins the first tie), watchdog count 0.
  - Outputs: grant_o=0, timeout_o=0, all ack/err=0, s_cyc_o=s_stb_o=s_we_o=0.
  - Reset overrides everything, including mid-burst. No ack is delivered after reset.
- States: IDLE, OWN0, OWN1. Requests are r0=m0_cyc_i&m0_stb_i and r1=m1_cyc_i&m1_stb_i.
- IDLE transitions:
  - r0 only: OWN0. r1 only: OWN1.
  - Both: the master != last wins.
  - On entry to OWNn, last<=n.
  - Request-to-s_cyc_o latency: 1 cycle (the grant is registered).
- OWNn:
  - Slave request outputs = master n's inputs combinationally; s_cyc_o=mn_cyc_i; s_stb_o=mn_stb_i.
  - s_ack_i/s_err_i are routed to mn_ack_o/mn_err_o only. The other master's ack/err are 0.
  - The losing master sees no ack and simply waits (stb held per Wishbone).
  - mn_cyc_i low at a posedge: go to IDLE. s_cyc_o is therefore low for at least one cycle between owners, even if the other master is waiting.
  - Ack and cyc drop in the same cycle: ack is delivered; next state is IDLE.
- In IDLE all slave outputs are 0, and adr/dat/sel are also 0.
- Watchdog (TIMEOUT_CYCLES>0):
  - Counts posedges in OWNn with s_stb_o=1 and s_ack_i=s_err_i=0; clears on ack, err, stb low, or leaving OWNn.
  - When count reaches TIMEOUT_CYCLES, on the next cycle:
    - mn_err_o=1 for exactly one cycle;
    - timeout_o=1 for exactly one cycle;
    - s_cyc_o=s_stb_o forced 0.
  - State then goes to IDLE and the counter clears.
  - A real s_ack_i arriving in the abort cycle is dropped (not forwarded).
- grant_o: registered one-hot of the state; 0 in IDLE.
- Burst lock: the grant never changes while the owner's cyc stays high, whatever the cti/stb gaps.
- No combinational path from mX_* inputs to grant/state.

Test Plan:
- Single m1 read, slave acks 2 cycles after stb: s_cyc_o rises 1 cycle after m1 request; m1_ack_o pulses once with s_dat_i=32'hDEADBEEF; m0_ack_o stays 0; grant_o=2'b10, then 0.
- Both request at the same posedge after reset: m0 granted first. After m0 drops cyc, s_cyc_o is low for ≥1 cycle, then m1 is granted. Repeating the tie grants m1 first.
- m0 8-beat incrementing burst (cti=3'b010, last beat 3'b111) while m1 requests: m1 waits through all 8 acks and is granted only after m0_cyc_i falls.
- TIMEOUT_CYCLES=16, slave never acks an m1 write: after 16 stalled cycles, m1_err_o and timeout_o pulse for one cycle, s_cyc_o=0, grant_o=0. A following m0 request is served normally.
- wb_rst_n low for 1 cycle mid m0 burst: next cycle s_cyc_o=0, grant_o=0, no further ack to m0. The pointer is reset, so a tie then grants m0.
- Ack coinciding with the owner's cyc drop, with the other master pending: ack delivered once; next owner granted after the IDLE cycle, with no duplicate ack.
